// File: rtl/smps_pkg.sv
// Shared encodings for the SMPS bridge sequencer: state codes, trip causes
// and the default over-current / over-voltage thresholds.
package smps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_SOFTSTART = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OCP  = 2'd1;
    localparam logic [1:0] FC_OVP  = 2'd2;

    localparam logic [23:0] OCP_LIMIT_DEF = 24'd11000000;
    localparam logic [23:0] OVP_LIMIT_DEF = 24'd900000;

endpackage

// File: rtl/smps_fault_detect.sv
// Over-current / over-voltage comparators. Strict greater-than, and OCP wins
// the cause encoding when both trip on the same sample.
module smps_fault_detect
    import smps_pkg::*;
#(
    parameter logic [23:0] OCP_LIMIT = OCP_LIMIT_DEF,
    parameter logic [23:0] OVP_LIMIT = OVP_LIMIT_DEF
) (
    input  logic        arm,
    input  logic        sense_valid,
    input  logic [23:0] vsense,
    input  logic [23:0] csense,
    output logic        trip,
    output logic [1:0]  code
);

    logic ocp;
    logic ovp;

    assign ocp = csense > OCP_LIMIT;
    assign ovp = vsense > OVP_LIMIT;

    always_comb begin
        trip = arm && sense_valid && (ocp || ovp);
        if (ocp)      code = FC_OCP;
        else if (ovp) code = FC_OVP;
        else          code = FC_NONE;
    end

endmodule

// File: rtl/smps_bridge_sequencer.sv
// Power-up sequencer for the ZVS bridge: precharge, phase-limit soft start,
// run, and trip handling with timed auto-retry and a latched lockout.
module smps_bridge_sequencer
    import smps_pkg::*;
#(
    parameter logic [15:0] PRECHARGE_CYCLES = 16'd1000,
    parameter logic [15:0] RAMP_DIV         = 16'd200,
    parameter logic [23:0] RETRY_CYCLES     = 24'd200000,
    parameter int          MAX_RETRIES      = 3,
    parameter logic [23:0] OCP_LIMIT        = OCP_LIMIT_DEF,
    parameter logic [23:0] OVP_LIMIT        = OVP_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sense_valid,
    input  logic [23:0] SMPS_50V_VSense,
    input  logic [23:0] SMPS_50V_CSense,
    input  logic        fault_clear,
    output logic        bridge_en,
    output logic [7:0]  phase_limit,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [1:0]  retry_cnt
);

    localparam logic [23:0] PRE_LAST   = {8'd0, PRECHARGE_CYCLES - 16'd1};
    localparam logic [23:0] RAMP_LAST  = {8'd0, RAMP_DIV - 16'd1};
    localparam logic [23:0] RETRY_LAST = RETRY_CYCLES - 24'd1;
    localparam logic [1:0]  MAX_R      = MAX_RETRIES[1:0];

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  phase_d;
    logic [1:0]  retry_d, code_d;
    logic        bridge_en_d, fault_d;
    logic        arm, trip;
    logic [1:0]  trip_code;

    assign state = state_q;
    assign arm   = (state_q == ST_PRECHARGE) || (state_q == ST_SOFTSTART) ||
                   (state_q == ST_RUN);

    smps_fault_detect #(
        .OCP_LIMIT (OCP_LIMIT),
        .OVP_LIMIT (OVP_LIMIT)
    ) u_fault_detect (
        .arm         (arm),
        .sense_valid (sense_valid),
        .vsense      (SMPS_50V_VSense),
        .csense      (SMPS_50V_CSense),
        .trip        (trip),
        .code        (trip_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_limit <= '0;
            retry_cnt   <= '0;
            fault_code  <= FC_NONE;
            bridge_en   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_limit <= phase_d;
            retry_cnt   <= retry_d;
            fault_code  <= code_d;
            bridge_en   <= bridge_en_d;
            fault       <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_limit;
        retry_d = retry_cnt;
        code_d  = fault_code;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (enable) begin
                    state_d = ST_PRECHARGE;
                    cnt_d   = '0;
                end
            end
            ST_PRECHARGE: begin
                phase_d = '0;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SOFTSTART;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_SOFTSTART: begin
                if (phase_limit == 8'hFF) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == RAMP_LAST) begin
                    cnt_d   = '0;
                    phase_d = phase_limit + 8'd1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_RUN: begin
                phase_d = 8'hFF;
                // Counter parks at the last value so the clear keeps holding.
                if (cnt_q == RETRY_LAST) retry_d = '0;
                else                     cnt_d   = cnt_q + 24'd1;
            end
            ST_FAULT: begin
                phase_d = '0;
                if (cnt_q == RETRY_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt < MAX_R) begin
                        retry_d = retry_cnt + 2'd1;
                        state_d = ST_PRECHARGE;
                    end else begin
                        state_d = ST_LOCKOUT;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_LOCKOUT: begin
                phase_d = '0;
                if (fault_clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    retry_d = '0;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                phase_d = '0;
            end
        endcase

        if (!enable && (arm || state_q == ST_FAULT)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = '0;
            retry_d = '0;
        end

        // A trip outranks a simultaneous disable so the cause is never lost.
        if (trip) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            phase_d = '0;
            code_d  = trip_code;
        end
    end

    always_comb begin
        bridge_en_d = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT) || (state_d == ST_LOCKOUT);
    end

endmodule

// File: tb/tb_smps_bridge_sequencer.sv
// Scoreboarded bench: each step queues the expected output snapshot, runs the
// clock, then pops and compares it against the sequencer outputs.
module tb_smps_bridge_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        sense_valid;
    logic [23:0] vsense;
    logic [23:0] csense;
    logic        fault_clear;
    logic        bridge_en;
    logic [7:0]  phase_limit;
    logic [2:0]  state;
    logic        fault;
    logic [1:0]  fault_code;
    logic [1:0]  retry_cnt;

    typedef struct packed {
        logic [2:0] st;
        logic       be;
        logic [7:0] pl;
        logic       flt;
        logic [1:0] fc;
        logic [1:0] rc;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    smps_bridge_sequencer #(
        .PRECHARGE_CYCLES (16'd8),
        .RAMP_DIV         (16'd2),
        .RETRY_CYCLES     (24'd16),
        .MAX_RETRIES      (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .sense_valid     (sense_valid),
        .SMPS_50V_VSense (vsense),
        .SMPS_50V_CSense (csense),
        .fault_clear     (fault_clear),
        .bridge_en       (bridge_en),
        .phase_limit     (phase_limit),
        .state           (state),
        .fault           (fault),
        .fault_code      (fault_code),
        .retry_cnt       (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Queue the expectation, advance n cycles, then score the DUT outputs.
    task automatic step(input int n, input string tag, input logic [2:0] st,
                        input logic be, input logic [7:0] pl, input logic flt,
                        input logic [1:0] fc, input logic [1:0] rc);
        snap_t e;
        string t;
        exp_q.push_back('{st: st, be: be, pl: pl, flt: flt, fc: fc, rc: rc});
        tag_q.push_back(tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".state"},       32'(state),       32'(e.st));
        chk({t, ".bridge_en"},   32'(bridge_en),   32'(e.be));
        chk({t, ".phase_limit"}, 32'(phase_limit), 32'(e.pl));
        chk({t, ".fault"},       32'(fault),       32'(e.flt));
        chk({t, ".fault_code"},  32'(fault_code),  32'(e.fc));
        chk({t, ".retry_cnt"},   32'(retry_cnt),   32'(e.rc));
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        sense_valid = 1'b0;
        vsense      = '0;
        csense      = '0;
        fault_clear = 1'b0;
        #12;
        step(0, "reset", 3'd0, 0, 8'd0, 0, 2'd0, 2'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Startup
        enable = 1'b1;
        step(1,   "pre",      3'd1, 0, 8'd0,   0, 2'd0, 2'd0);
        step(7,   "pre_hold", 3'd1, 0, 8'd0,   0, 2'd0, 2'd0);
        step(1,   "soft",     3'd2, 1, 8'd0,   0, 2'd0, 2'd0);
        step(2,   "ramp1",    3'd2, 1, 8'd1,   0, 2'd0, 2'd0);
        step(508, "ramp255",  3'd2, 1, 8'd255, 0, 2'd0, 2'd0);
        step(1,   "run",      3'd3, 1, 8'd255, 0, 2'd0, 2'd0);
        step(5,   "run_hold", 3'd3, 1, 8'd255, 0, 2'd0, 2'd0);

        // OCP in RUN, fault_clear ignored in FAULT, auto retry
        csense = 24'd11777216; sense_valid = 1'b1;
        step(1, "ocp", 3'd4, 0, 8'd0, 1, 2'd1, 2'd0);
        sense_valid = 1'b0; csense = '0;
        fault_clear = 1'b1;
        step(1, "fc_ignored", 3'd4, 0, 8'd0, 1, 2'd1, 2'd0);
        fault_clear = 1'b0;
        step(14, "fault_hold", 3'd4, 0, 8'd0, 1, 2'd1, 2'd0);
        step(1,  "retry1",     3'd1, 0, 8'd0, 0, 2'd1, 2'd1);

        // Out-of-range values without sense_valid must not trip
        vsense = 24'hFFFFFF; csense = 24'hFFFFFF;
        step(1, "nv_ignored", 3'd1, 0, 8'd0, 0, 2'd1, 2'd1);
        vsense = '0; csense = '0;
        step(7,   "soft2",          3'd2, 1, 8'd0,   0, 2'd1, 2'd1);
        step(510, "ramp2",          3'd2, 1, 8'd255, 0, 2'd1, 2'd1);
        step(1,   "run2",           3'd3, 1, 8'd255, 0, 2'd1, 2'd1);
        step(15,  "run_retry_hold", 3'd3, 1, 8'd255, 0, 2'd1, 2'd1);
        step(1,   "retry_clr",      3'd3, 1, 8'd255, 0, 2'd1, 2'd0);

        // Values equal to the limits do not trip; OVP alone does
        vsense = 24'd900000; csense = 24'd11000000; sense_valid = 1'b1;
        step(1, "eq_limit", 3'd3, 1, 8'd255, 0, 2'd1, 2'd0);
        vsense = 24'd900001; csense = '0;
        step(1, "ovp", 3'd4, 0, 8'd0, 1, 2'd2, 2'd0);
        sense_valid = 1'b0; vsense = '0;
        step(16, "retry_a", 3'd1, 0, 8'd0, 0, 2'd2, 2'd1);

        // Simultaneous trip in PRECHARGE reports OCP, then run out of retries
        vsense = 24'd900001; csense = 24'd11000001; sense_valid = 1'b1;
        step(1, "both", 3'd4, 0, 8'd0, 1, 2'd1, 2'd1);
        sense_valid = 1'b0; vsense = '0; csense = '0;
        step(16, "retry_b", 3'd1, 0, 8'd0, 0, 2'd1, 2'd2);
        csense = 24'd11000001; sense_valid = 1'b1;
        step(1, "trip3", 3'd4, 0, 8'd0, 1, 2'd1, 2'd2);
        sense_valid = 1'b0; csense = '0;
        step(16, "lockout", 3'd5, 0, 8'd0, 1, 2'd1, 2'd2);

        enable = 1'b0;
        step(3, "lock_en0", 3'd5, 0, 8'd0, 1, 2'd1, 2'd2);
        enable = 1'b1;
        step(2, "lock_en1", 3'd5, 0, 8'd0, 1, 2'd1, 2'd2);
        enable = 1'b0; fault_clear = 1'b1;
        step(1, "clear", 3'd0, 0, 8'd0, 0, 2'd0, 2'd0);
        fault_clear = 1'b0;

        // Asynchronous reset mid-ramp, then a clean restart
        enable = 1'b1;
        step(1,  "pre3",   3'd1, 0, 8'd0,  0, 2'd0, 2'd0);
        step(8,  "soft3",  3'd2, 1, 8'd0,  0, 2'd0, 2'd0);
        step(80, "ramp40", 3'd2, 1, 8'd40, 0, 2'd0, 2'd0);
        #1 rst_n = 1'b0;
        #1;
        step(0, "async_rst", 3'd0, 0, 8'd0, 0, 2'd0, 2'd0);
        #4 rst_n = 1'b1;
        step(1,   "pre4",  3'd1, 0, 8'd0,   0, 2'd0, 2'd0);
        step(8,   "soft4", 3'd2, 1, 8'd0,   0, 2'd0, 2'd0);
        step(2,   "ramp4", 3'd2, 1, 8'd1,   0, 2'd0, 2'd0);
        step(509, "run4",  3'd3, 1, 8'd255, 0, 2'd0, 2'd0);
        enable = 1'b0;
        step(1, "dis_run", 3'd0, 0, 8'd0, 0, 2'd0, 2'd0);

        // Trip coincident with disable goes to FAULT; disable then keeps the cause
        enable = 1'b1;
        step(1, "pre5", 3'd1, 0, 8'd0, 0, 2'd0, 2'd0);
        enable = 1'b0; vsense = 24'd900001; sense_valid = 1'b1;
        step(1, "trip_vs_dis", 3'd4, 0, 8'd0, 1, 2'd2, 2'd0);
        sense_valid = 1'b0; vsense = '0;
        step(1, "dis_fault", 3'd0, 0, 8'd0, 0, 2'd2, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smps_bridge_sequencer.md
SMPS_BRIDGE_SEQUENCER -- requirements
Module: smps_bridge_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameter PRECHARGE_CYCLES, default 16'd1000, SHALL set the dwell time in PRECHARGE, in clk cycles.
REQ-003 Parameter RAMP_DIV, default 16'd200, SHALL set the number of clk cycles per phase_limit step in SOFTSTART.
REQ-004 Parameter RETRY_CYCLES, default 24'd200000, SHALL set the FAULT hold time and the RUN time needed to clear retries.
REQ-005 Parameter MAX_RETRIES, default 3, SHALL set the number of automatic restarts allowed before LOCKOUT.
REQ-006 Parameters OCP_LIMIT (default 24'd11000000) and OVP_LIMIT (default 24'd900000) SHALL be the unsigned trip thresholds.
REQ-007 Ports SHALL be:
- clk  in  1  200 MHz system clock
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  level-sensitive converter run request
- sense_valid  in  1  one-cycle strobe qualifying both sense buses
- SMPS_50V_VSense  in  24  unsigned output-voltage sample
- SMPS_50V_CSense  in  24  unsigned bridge-current sample
- fault_clear  in  1  one-cycle strobe that releases LOCKOUT
- bridge_en  out  1  gate enable to the ZVS bridge controller
- phase_limit  out  8  maximum phase shift allowed to the ZVS controller
- state  out  3  current state encoding
- fault  out  1  high in FAULT and in LOCKOUT
- fault_code  out  2  last trip cause: 0 none, 1 OCP, 2 OVP
- retry_cnt  out  2  number of restarts since the last clear

Function
REQ-008 All outputs SHALL be registered; every state transition SHALL take effect on the clk edge after its condition is sampled.
REQ-009 The states SHALL be IDLE=0, PRECHARGE=1, SOFTSTART=2, RUN=3, FAULT=4 and LOCKOUT=5; codes 6 and 7 SHALL recover to IDLE.
REQ-010 IDLE: bridge_en=0 and phase_limit=0; with enable=1 the block SHALL go to PRECHARGE and clear the cycle counter.
REQ-011 PRECHARGE: bridge_en=0; after exactly PRECHARGE_CYCLES cycles in the state, the block SHALL go to SOFTSTART.
REQ-012 SOFTSTART: bridge_en=1; phase_limit SHALL start at 0 and increment by 1 every RAMP_DIV cycles, saturating at 255.
REQ-013 The cycle after phase_limit reaches 255, the block SHALL go to RUN.
REQ-014 RUN: bridge_en=1 and phase_limit=255; after RETRY_CYCLES continuous cycles in RUN, retry_cnt SHALL clear to 0.
REQ-015 Trip detection SHALL be active only in PRECHARGE, SOFTSTART and RUN, and only when sense_valid=1:
- OCP when CSense > OCP_LIMIT
- OVP when VSense > OVP_LIMIT
- strict greater-than; a value equal to the limit SHALL NOT trip
REQ-016 When OCP and OVP occur on the same sample, fault_code SHALL be 1 (OCP).
REQ-017 On a trip, on the next edge: state=FAULT, bridge_en=0, phase_limit=0, fault=1, fault_code latched, cycle counter cleared.
REQ-018 FAULT SHALL hold for RETRY_CYCLES; then, if retry_cnt < MAX_RETRIES, retry_cnt SHALL increment and the block go to PRECHARGE.
REQ-019 Otherwise FAULT SHALL go to LOCKOUT, where bridge_en=0 and fault=1.
REQ-020 LOCKOUT SHALL ignore enable; fault_clear SHALL return it to IDLE, clearing fault, fault_code and retry_cnt.
REQ-021 enable=0 in PRECHARGE, SOFTSTART, RUN or FAULT SHALL send the block to IDLE on the next edge.
REQ-022 That transition SHALL clear fault and retry_cnt; fault_code SHALL retain the last cause.
REQ-023 A trip sampled on the same cycle as enable=0 SHALL take priority: the block goes to FAULT, with fault_code latched.
REQ-024 fault_clear outside LOCKOUT SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, bridge_en=0, phase_limit=0, fault=0, fault_code=0, retry_cnt=0 and all counters to 0.
REQ-026 Reset mid-SOFTSTART or mid-FAULT SHALL leave no residual ramp or retry history.

Structure
REQ-027 Package smps_pkg SHALL hold the state encodings, the fault_code constants and the default OCP/OVP limits.
REQ-028 Sub-module smps_fault_detect SHALL contain the two comparators and the OCP-over-OVP priority encoding.

Verification
Bench parameters: PRECHARGE_CYCLES=8, RAMP_DIV=2, RETRY_CYCLES=16, MAX_RETRIES=2.
REQ-029 Startup: assert enable -> PRECHARGE after 1 cycle, SOFTSTART after 8 more, phase_limit=255 after 510 cycles, then RUN.
REQ-030 OCP in RUN: CSense=24'd11777216 with sense_valid -> next edge FAULT, bridge_en=0, fault_code=1; PRECHARGE 16 cycles later with retry_cnt=1.
REQ-031 Simultaneous and boundary trips: VSense=24'd900001 with CSense=24'd11000001 -> fault_code=1; VSense=24'd900000 alone -> no trip.
REQ-032 Lockout: trips on three consecutive restarts -> LOCKOUT with retry_cnt=2; enable toggling has no effect; fault_clear -> IDLE with all flags 0.
REQ-033 Asynchronous reset mid-SOFTSTART (phase_limit=40) -> all outputs 0 immediately; enable=0 in RUN -> IDLE next edge.
